// File: rtl/alveo_hls4ml_mul_acc_pipe_if.sv
// Operand/result bundle for the pipelined multiply-accumulate unit.
// master = producer of operands (fetch side), slave = the MAC unit itself.
interface alveo_hls4ml_mul_acc_pipe_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 13,
  parameter int DOUT_WIDTH = 32
);
  logic                         ce;
  logic                         in_valid;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         acc_en;
  logic                         acc_clr;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         out_valid;
  logic                         acc_ovf;

  modport master (
    output ce, in_valid, din0, din1, acc_en, acc_clr,
    input  dout, out_valid, acc_ovf
  );

  modport slave (
    input  ce, in_valid, din0, din1, acc_en, acc_clr,
    output dout, out_valid, acc_ovf
  );
endinterface

// File: rtl/alveo_hls4ml_mul_acc_pipe.sv
// Pipelined signed multiply / multiply-accumulate for hls4ml dense layers.
// Define MUL_ACC_SAT_EN for saturating resize/accumulate with a sticky acc_ovf; default wraps.
module alveo_hls4ml_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 13,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 4
) (
  input  logic clk,
  input  logic reset,
  alveo_hls4ml_mul_acc_pipe_if.slave bus
);

  localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;
  // Registers from the product stage up to (not including) the output stage.
  localparam int D   = NUM_STAGE - 2;

  if (NUM_STAGE < 3 || NUM_STAGE > 8) begin : g_bad_depth
    $error("NUM_STAGE must be in 3..8");
  end

`ifdef MUL_ACC_SAT_EN
  localparam int SW = ((P_W > DOUT_WIDTH) ? P_W : DOUT_WIDTH) + 1;
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // Returns {overflow, clamped value}.
  function automatic logic [DOUT_WIDTH:0] sat_fit(input logic signed [SW-1:0] v);
    logic [DOUT_WIDTH:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[DOUT_WIDTH-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[DOUT_WIDTH-1:0]};
    else                  r = {1'b0, v[DOUT_WIDTH-1:0]};
    return r;
  endfunction
`endif

  logic signed [DIN0_WIDTH-1:0] din0_p1_q, din0_p1_d;
  logic signed [DIN1_WIDTH-1:0] din1_p1_q, din1_p1_d;
  logic                         vld_p1_q, vld_p1_d;
  logic                         en_p1_q, en_p1_d;
  logic                         clr_p1_q, clr_p1_d;

  logic signed [P_W-1:0] prod_dly_q [D];
  logic signed [P_W-1:0] prod_dly_d [D];
  logic                  vld_dly_q  [D];
  logic                  vld_dly_d  [D];
  logic                  en_dly_q   [D];
  logic                  en_dly_d   [D];
  logic                  clr_dly_q  [D];
  logic                  clr_dly_d  [D];

  logic signed [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         out_valid_q, out_valid_d;
  logic                         acc_ovf_q, acc_ovf_d;

  logic signed [P_W-1:0] prod_last;
  logic [DOUT_WIDTH:0]   prod_fit;
  logic [DOUT_WIDTH:0]   sum_fit;

  assign prod_last = prod_dly_q[D-1];

  // Resize of the product alone and of accumulator + product; MSB flags saturation.
`ifdef MUL_ACC_SAT_EN
  assign prod_fit = sat_fit(SW'(prod_last));
  assign sum_fit  = sat_fit(SW'(acc_q) + SW'(prod_last));
`else
  assign prod_fit = {1'b0, DOUT_WIDTH'(prod_last)};
  assign sum_fit  = {1'b0, acc_q + DOUT_WIDTH'(prod_last)};
`endif

  always_comb begin
    din0_p1_d   = din0_p1_q;
    din1_p1_d   = din1_p1_q;
    vld_p1_d    = vld_p1_q;
    en_p1_d     = en_p1_q;
    clr_p1_d    = clr_p1_q;
    prod_dly_d  = prod_dly_q;
    vld_dly_d   = vld_dly_q;
    en_dly_d    = en_dly_q;
    clr_dly_d   = clr_dly_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    acc_ovf_d   = acc_ovf_q;

    if (bus.ce) begin
      // stage 1: operand / control capture
      din0_p1_d = bus.din0;
      din1_p1_d = bus.din1;
      vld_p1_d  = bus.in_valid;
      en_p1_d   = bus.acc_en;
      clr_p1_d  = bus.acc_en & bus.acc_clr;

      // stage 2: exact full-width product
      prod_dly_d[0] = P_W'(din0_p1_q) * P_W'(din1_p1_q);
      vld_dly_d[0]  = vld_p1_q;
      en_dly_d[0]   = en_p1_q;
      clr_dly_d[0]  = clr_p1_q;

      // stages 3..NUM_STAGE-1: delay line
      for (int i = 1; i < D; i++) begin
        prod_dly_d[i] = prod_dly_q[i-1];
        vld_dly_d[i]  = vld_dly_q[i-1];
        en_dly_d[i]   = en_dly_q[i-1];
        clr_dly_d[i]  = clr_dly_q[i-1];
      end

      // stage NUM_STAGE: output / accumulate; bubbles leave acc and dout alone
      out_valid_d = vld_dly_q[D-1];
      if (vld_dly_q[D-1]) begin
        if (!en_dly_q[D-1]) begin
          dout_d    = prod_fit[DOUT_WIDTH-1:0];
          acc_ovf_d = acc_ovf_q | prod_fit[DOUT_WIDTH];
        end else if (clr_dly_q[D-1]) begin
          acc_d     = prod_fit[DOUT_WIDTH-1:0];
          dout_d    = prod_fit[DOUT_WIDTH-1:0];
          acc_ovf_d = prod_fit[DOUT_WIDTH];
        end else begin
          acc_d     = sum_fit[DOUT_WIDTH-1:0];
          dout_d    = sum_fit[DOUT_WIDTH-1:0];
          acc_ovf_d = acc_ovf_q | sum_fit[DOUT_WIDTH];
        end
      end
    end

`ifndef MUL_ACC_SAT_EN
    acc_ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din0_p1_q   <= '0;
      din1_p1_q   <= '0;
      vld_p1_q    <= 1'b0;
      en_p1_q     <= 1'b0;
      clr_p1_q    <= 1'b0;
      for (int i = 0; i < D; i++) begin
        prod_dly_q[i] <= '0;
        vld_dly_q[i]  <= 1'b0;
        en_dly_q[i]   <= 1'b0;
        clr_dly_q[i]  <= 1'b0;
      end
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else begin
      din0_p1_q   <= din0_p1_d;
      din1_p1_q   <= din1_p1_d;
      vld_p1_q    <= vld_p1_d;
      en_p1_q     <= en_p1_d;
      clr_p1_q    <= clr_p1_d;
      prod_dly_q  <= prod_dly_d;
      vld_dly_q   <= vld_dly_d;
      en_dly_q    <= en_dly_d;
      clr_dly_q   <= clr_dly_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_alveo_hls4ml_mul_acc_pipe.sv
// Directed bench for alveo_hls4ml_mul_acc_pipe: a default 32-bit instance and a 16-bit-output instance.
// Expectations for the 16-bit instance follow MUL_ACC_SAT_EN when it is defined.
module tb_alveo_hls4ml_mul_acc_pipe;
  localparam int DW0 = 16;
  localparam int DW1 = 13;
  localparam int DOW = 32;
  localparam int DOB = 16;
  localparam int NS  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alveo_hls4ml_mul_acc_pipe_if #(.DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOW)) bus_a ();
  alveo_hls4ml_mul_acc_pipe_if #(.DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOB)) bus_b ();

  alveo_hls4ml_mul_acc_pipe #(
    .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOW), .NUM_STAGE(NS)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus_a));

  alveo_hls4ml_mul_acc_pipe #(
    .DIN0_WIDTH(DW0), .DIN1_WIDTH(DW1), .DOUT_WIDTH(DOB), .NUM_STAGE(NS)
  ) u_dut16 (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input int a, input int b, input logic en, input logic clr);
    bus_a.in_valid = v;
    bus_a.din0     = DW0'(a);
    bus_a.din1     = DW1'(b);
    bus_a.acc_en   = en;
    bus_a.acc_clr  = clr;
  endtask

  task automatic drive_b(input logic v, input int a, input int b, input logic en, input logic clr);
    bus_b.in_valid = v;
    bus_b.din0     = DW0'(a);
    bus_b.din1     = DW1'(b);
    bus_b.acc_en   = en;
    bus_b.acc_clr  = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.ce = 1'b1;
    drive_a(1'b1, 5, 5, 1'b1, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      step();
      n_cmp++;
      if (bus_a.out_valid !== 1'b0 || bus_a.dout !== 0 || bus_a.acc_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got vld=%b dout=%0d ovf=%b, want 0/0/0",
                 c, bus_a.out_valid, bus_a.dout, bus_a.acc_ovf);
      end
    end
    reset = 1'b0;
    drive_a(1'b0, 0, 0, 1'b0, 1'b0);
    for (int c = 1; c <= NS; c++) begin
      step();
      n_cmp++;
      if (bus_a.out_valid !== 1'b0 || bus_a.dout !== 0 || bus_b.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release cyc=%0d got vld=%b dout=%0d vld16=%b, want 0/0/0",
                 c, bus_a.out_valid, bus_a.dout, bus_b.out_valid);
      end
    end
  endtask

  task automatic test_multiply();
    drive_a(1'b1, -3, 5, 1'b0, 1'b0);
    step();
    drive_a(1'b0, 0, 0, 1'b0, 1'b0);
    for (int c = 2; c <= NS; c++) begin
      step();
      if (c < NS) begin
        n_cmp++;
        if (bus_a.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL mul_early cyc=%0d got vld=%b want 0", c, bus_a.out_valid);
        end
      end else begin
        n_cmp++;
        if (bus_a.out_valid !== 1'b1 || bus_a.dout !== -15) begin
          n_err++;
          $display("FAIL mul_result got vld=%b dout=%0d want 1/-15", bus_a.out_valid, bus_a.dout);
        end
      end
    end
    bus_a.ce = 1'b0;
    step();
    n_cmp++;
    if (bus_a.out_valid !== 1'b1 || bus_a.dout !== -15) begin
      n_err++;
      $display("FAIL mul_ce_freeze got vld=%b dout=%0d want 1/-15", bus_a.out_valid, bus_a.dout);
    end
    bus_a.ce = 1'b1;
    step();
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_a.dout !== -15) begin
      n_err++;
      $display("FAIL mul_one_pulse got vld=%b dout=%0d want 0/-15", bus_a.out_valid, bus_a.dout);
    end
  endtask

  task automatic test_accumulate();
    int a_v[4] = '{100, -50, 7, 1};
    int b_v[4] = '{2, 3, 7, 1};
    int exp_d[4] = '{200, 50, 99, 100};
    int idx = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c <= 4) drive_a(1'b1, a_v[c-1], b_v[c-1], 1'b1, c == 1);
      else        drive_a(1'b0, 0, 0, 1'b0, 1'b0);
      step();
      if (bus_a.out_valid === 1'b1) begin
        n_cmp++;
        if (idx >= 4) begin
          n_err++;
          $display("FAIL acc_extra cyc=%0d got dout=%0d want no result", c, bus_a.dout);
        end else if (c != NS + idx || bus_a.dout !== exp_d[idx]) begin
          n_err++;
          $display("FAIL acc_result%0d cyc=%0d dout=%0d want cyc=%0d dout=%0d",
                   idx, c, bus_a.dout, NS + idx, exp_d[idx]);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4) begin
      n_err++;
      $display("FAIL acc_count got %0d results want 4", idx);
    end
  endtask

  task automatic test_stall();
    int a_v[4] = '{100, -50, 7, 1};
    int b_v[4] = '{2, 3, 7, 1};
    int exp_d[4] = '{200, 50, 99, 100};
    int exp_c[4] = '{7, 8, 9, 10};
    int s = 0;
    int idx = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c >= 3 && c <= 5) begin
        bus_a.ce = 1'b0;
        drive_a(1'b1, 999, -7, 1'b1, 1'b1);
      end else begin
        bus_a.ce = 1'b1;
        if (s < 4) begin
          drive_a(1'b1, a_v[s], b_v[s], 1'b1, s == 0);
          s++;
        end else begin
          drive_a(1'b0, 0, 0, 1'b0, 1'b0);
        end
      end
      step();
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (bus_a.out_valid !== 1'b0 || bus_a.dout !== 100) begin
          n_err++;
          $display("FAIL stall_frozen cyc=%0d got vld=%b dout=%0d want 0/100",
                   c, bus_a.out_valid, bus_a.dout);
        end
      end
      if (bus_a.out_valid === 1'b1) begin
        n_cmp++;
        if (idx >= 4) begin
          n_err++;
          $display("FAIL stall_extra cyc=%0d dout=%0d want no result", c, bus_a.dout);
        end else if (c != exp_c[idx] || bus_a.dout !== exp_d[idx]) begin
          n_err++;
          $display("FAIL stall_result%0d cyc=%0d dout=%0d want cyc=%0d dout=%0d",
                   idx, c, bus_a.dout, exp_c[idx], exp_d[idx]);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 4) begin
      n_err++;
      $display("FAIL stall_count got %0d results want 4", idx);
    end
  endtask

  task automatic test_bubble_gap();
    int exp_d[2] = '{100, 105};
    int exp_c[2] = '{5, 8};
    int idx = 0;
    for (int c = 1; c <= 12; c++) begin
      bus_a.ce = (c != 4);
      if (c == 1)      drive_a(1'b1, 10, 10, 1'b1, 1'b1);
      else if (c == 5) drive_a(1'b1, 1, 5, 1'b1, 1'b0);
      else             drive_a(1'b0, 1000, 1000, 1'b1, 1'b1);
      step();
      if (bus_a.out_valid === 1'b1) begin
        n_cmp++;
        if (idx >= 2) begin
          n_err++;
          $display("FAIL gap_extra cyc=%0d dout=%0d want no result", c, bus_a.dout);
        end else if (c != exp_c[idx] || bus_a.dout !== exp_d[idx]) begin
          n_err++;
          $display("FAIL gap_result%0d cyc=%0d dout=%0d want cyc=%0d dout=%0d",
                   idx, c, bus_a.dout, exp_c[idx], exp_d[idx]);
        end
        idx++;
      end
    end
    bus_a.ce = 1'b1;
    n_cmp++;
    if (idx != 2) begin
      n_err++;
      $display("FAIL gap_count got %0d results want 2", idx);
    end
  endtask

  task automatic test_overflow();
    int a_v[7] = '{300, 100, 100, 100, -1, 1, 1};
    int b_v[7] = '{200, 100, 100, 200, 1, 1, 1};
    logic en_v[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic clr_v[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef MUL_ACC_SAT_EN
    int   exp_d[7]   = '{32767, 10000, 20000, 32767, -1, 32767, 1};
    logic exp_ovf[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    int   exp_d[7]   = '{-5536, 10000, 20000, -25536, -1, -25535, 1};
    logic exp_ovf[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    int idx = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 7) drive_b(1'b1, a_v[c-1], b_v[c-1], en_v[c-1], clr_v[c-1]);
      else        drive_b(1'b0, 0, 0, 1'b0, 1'b0);
      step();
      if (bus_b.out_valid === 1'b1) begin
        n_cmp++;
        if (idx >= 7) begin
          n_err++;
          $display("FAIL ovf_extra cyc=%0d dout=%0d want no result", c, bus_b.dout);
        end else if (c != NS + idx || bus_b.dout !== exp_d[idx] || bus_b.acc_ovf !== exp_ovf[idx]) begin
          n_err++;
          $display("FAIL ovf_result%0d cyc=%0d dout=%0d ovf=%b want cyc=%0d dout=%0d ovf=%b",
                   idx, c, bus_b.dout, bus_b.acc_ovf, NS + idx, exp_d[idx], exp_ovf[idx]);
        end
        idx++;
      end
    end
    n_cmp++;
    if (idx != 7) begin
      n_err++;
      $display("FAIL ovf_count got %0d results want 7", idx);
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 1; c <= 3; c++) begin
      drive_a(1'b1, 5, 5, 1'b0, 1'b0);
      step();
    end
    drive_a(1'b0, 0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_a.dout !== 0 || bus_a.acc_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear got vld=%b dout=%0d ovf=%b want 0/0/0",
               bus_a.out_valid, bus_a.dout, bus_a.acc_ovf);
    end
    for (int c = 5; c <= 12; c++) begin
      if (c == 5) drive_a(1'b1, 4, 4, 1'b1, 1'b0);
      else        drive_a(1'b0, 0, 0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (c == 8) begin
        if (bus_a.out_valid !== 1'b1 || bus_a.dout !== 16) begin
          n_err++;
          $display("FAIL midrst_result cyc=%0d got vld=%b dout=%0d want 1/16",
                   c, bus_a.out_valid, bus_a.dout);
        end
      end else if (bus_a.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stray cyc=%0d got vld=%b want 0", c, bus_a.out_valid);
      end
    end
  endtask

  initial begin
    bus_b.ce = 1'b1;
    drive_b(1'b0, 0, 0, 1'b0, 1'b0);
    test_reset();
    test_multiply();
    test_accumulate();
    test_stall();
    test_bubble_gap();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
